// File: rtl/demux8_pkg.sv
// Shared constants and types for the 8-way write demux.
// The buffer-entry struct is declared in the top because its data width is a parameter there.
package demux8_pkg;
  localparam int NUM_TARGETS = 8;
  localparam int SEL_WIDTH   = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// Per-target beat counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_WIDTH'(1);
    end
  end
endmodule

// File: rtl/demux8_wr.sv
// 8-way write-stream demux with a 2-entry skid buffer; in_ready_o comes straight from the state flop.
// Optional per-target drain counters are built when DEMUX8_STATS_EN is defined.
module demux8_wr
  import demux8_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [SEL_WIDTH-1:0]           sel_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  output logic [NUM_TARGETS-1:0]         out_valid_o,
  input  logic [NUM_TARGETS-1:0]         out_ready_i,
  output logic [SEL_WIDTH-1:0]           out_sel_o,
  output logic [DATA_WIDTH-1:0]          out_data_o,
  output logic [NUM_TARGETS*CNT_WIDTH-1:0] beat_cnt_o
);
  // state | meaning
  // EMPTY | nothing held
  // BUSY  | main entry valid and presented
  // FULL  | main and skid valid; upstream stalled

  typedef struct packed {
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t state, state_n;
  entry_t main_q, main_n, skid_q, skid_n, in_entry;
  logic   acc, drn;

  assign in_entry    = '{sel: sel_i, data: data_i};
  assign in_ready_o  = (state != FULL);
  assign acc         = in_valid_i && in_ready_o;
  // Ready bits of non-selected targets never matter.
  assign drn         = (state != EMPTY) && out_ready_i[main_q.sel];
  assign out_valid_o = (state != EMPTY) ? (NUM_TARGETS'(1) << main_q.sel) : '0;
  assign out_sel_o   = main_q.sel;
  assign out_data_o  = main_q.data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    case (state)
      EMPTY: begin
        if (acc) begin
          main_n  = in_entry;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (acc && drn) begin
          main_n = in_entry;
        end else if (acc) begin
          skid_n  = in_entry;
          state_n = FULL;
        end else if (drn) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (drn) begin
          main_n  = skid_q;
          state_n = BUSY;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

`ifdef DEMUX8_STATS_EN
  for (genvar n = 0; n < NUM_TARGETS; n++) begin : g_cnt
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (drn && (main_q.sel == SEL_WIDTH'(n))),
      .cnt_o (beat_cnt_o[n*CNT_WIDTH +: CNT_WIDTH])
    );
  end
`else
  assign beat_cnt_o = '0;
`endif
endmodule

// File: tb/tb_demux8_wr.sv
// Bench for demux8_wr: directed scenarios plus random traffic checked against a FIFO-queue model.
module tb_demux8_wr;
  localparam int CW = 4;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  sel = '0;
  logic [31:0] data = '0;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = '0;
  logic [2:0]  out_sel;
  logic [31:0] out_data;
  logic [8*CW-1:0] beat_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
  } beat_t;

  beat_t q[$];
  int    cnt_m[8];

  always #5 clk_sys = ~clk_sys;

  demux8_wr #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk_i       (clk_sys),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sel_i       (sel),
    .data_i      (data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sel_o   (out_sel),
    .out_data_o  (out_data),
    .beat_cnt_o  (beat_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8*CW-1:0] exp_cnt();
    logic [8*CW-1:0] e;
    e = '0;
`ifdef DEMUX8_STATS_EN
    for (int n = 0; n < 8; n++) e[n*CW +: CW] = CW'(cnt_m[n]);
`endif
    return e;
  endfunction

  task automatic check_outputs();
    logic [7:0] ev;
    ev = (q.size() > 0) ? (8'b1 << q[0].sel) : 8'b0;
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (q.size() > 0) begin
      chk("out_sel", 64'(out_sel), 64'(q[0].sel));
      chk("out_data", 64'(out_data), 64'(q[0].data));
    end
    chk("beat_cnt", 64'(beat_cnt), 64'(exp_cnt()));
  endtask

  // Drive one cycle of stimulus, check outputs, advance the queue model across the edge.
  task automatic step(input logic v, input logic [2:0] s, input logic [31:0] d, input logic [7:0] r);
    bit    acc_m, drn_m;
    beat_t b;
    in_valid  = v;
    sel       = s;
    data      = d;
    out_ready = r;
    #1;
    check_outputs();
    acc_m = v && (q.size() < 2);
    drn_m = (q.size() > 0) && r[q[0].sel];
    @(posedge clk_sys);
    #1;
    if (drn_m) begin
      if (cnt_m[q[0].sel] < (1 << CW) - 1) cnt_m[q[0].sel]++;
      void'(q.pop_front());
    end
    if (acc_m) begin
      b.sel  = s;
      b.data = d;
      q.push_back(b);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'h0);
    chk({tag, "_data"}, 64'(out_data), 64'h0);
    chk({tag, "_sel"}, 64'(out_sel), 64'h0);
    chk({tag, "_ready"}, 64'(in_ready), 64'h1);
    chk({tag, "_cnt"}, 64'(beat_cnt), 64'h0);
  endtask

  initial begin
    for (int n = 0; n < 8; n++) cnt_m[n] = 0;
    #2;
    reset_checks("rst_init");
    @(posedge clk_sys);
    #1;
    rst = 1'b0;

    // single beat held while target not ready
    step(1'b1, 3'd5, 32'hDEADBEEF, 8'h00);
    chk("single_valid", 64'(out_valid), 64'h20);
    for (int i = 0; i < 10; i++) step(1'b0, 3'd0, 32'h0, 8'h00);
    step(1'b0, 3'd0, 32'h0, 8'h20);
    chk("single_drained", 64'(out_valid), 64'h00);

    // back-to-back throughput with every target ready
    for (int i = 0; i < 16; i++) step(1'b1, 3'(i % 8), 32'h100 + 32'(i), 8'hFF);
    step(1'b0, 3'd0, 32'h0, 8'hFF);
    chk("thru_empty", 64'(out_valid), 64'h00);

    // skid fills, third beat refused, then drains in order
    step(1'b1, 3'd2, 32'hAAAA0001, 8'h00);
    step(1'b1, 3'd3, 32'hBBBB0002, 8'h00);
    chk("skid_full_ready", 64'(in_ready), 64'h0);
    step(1'b1, 3'd7, 32'hCCCC0003, 8'h00);
    step(1'b0, 3'd0, 32'h0, 8'h04);
    chk("skid_b_valid", 64'(out_valid), 64'h08);
    chk("skid_b_data", 64'(out_data), 64'hBBBB0002);
    chk("skid_b_ready", 64'(in_ready), 64'h1);
    step(1'b0, 3'd0, 32'h0, 8'h08);

    // wrong-target ready is ignored
    step(1'b1, 3'd1, 32'h11112222, 8'hFD);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 32'h0, 8'hFD);
    chk("wrong_tgt_held", 64'(out_valid), 64'h02);
    step(1'b0, 3'd0, 32'h0, 8'h02);

    // reset asserted mid-cycle with the buffer full
    step(1'b1, 3'd4, 32'h44440000, 8'h00);
    step(1'b1, 3'd6, 32'h66660000, 8'h00);
    #3;
    rst = 1'b1;
    #1;
    reset_checks("rst_mid");
    q.delete();
    for (int n = 0; n < 8; n++) cnt_m[n] = 0;
    in_valid = 1'b0;
    @(posedge clk_sys);
    #1;
    rst = 1'b0;

    // 20 beats to target 7 saturate its counter in the stats build
    for (int i = 0; i < 20; i++) step(1'b1, 3'd7, 32'h700 + 32'(i), 8'h80);
    step(1'b0, 3'd0, 32'h0, 8'h00);
    step(1'b0, 3'd0, 32'h0, 8'h00);
`ifdef DEMUX8_STATS_EN
    chk("stats_sat", 64'(beat_cnt[7*CW +: CW]), 64'hF);
`else
    chk("stats_off", 64'(beat_cnt), 64'h0);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), 32'($urandom),
           8'($urandom) | (($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 32'h0, 8'hFF);
    chk("final_empty", 64'(out_valid), 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
